// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/grant + response-valid bus between fetch and memory.
interface instruction_fetch_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemGnt;
   logic [31:0] IMemRdata;
   logic        IMemRvalid;

   modport master (output IMemReq, IMemAddr, input IMemGnt, IMemRdata, IMemRvalid);
   modport slave  (input IMemReq, IMemAddr, output IMemGnt, IMemRdata, IMemRvalid);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single outstanding imem request, one-entry stall buffer and IF/ID register.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst_n,
   instruction_fetch_if.master imem,
   input  logic                Redirect,
   input  logic [31:0]         RedirectPC,
   input  logic                Stall,
   output logic [31:0]         Inst,
   output logic [31:0]         InstPC,
   output logic                InstValid
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DROP = 3'd3,
      FULL = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] buf_q, buf_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            inst_valid_q, inst_valid_d;
   logic            req_q, req_d;

   logic            acc;
   logic            load;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] redirect_pc;

   assign acc         = !Stall || !inst_valid_q;
   assign redirect_pc = RedirectPC & ALIGN_MASK;

   // Next-state, PC bookkeeping and IF/ID register update
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      buf_d        = buf_q;
      load         = 1'b0;
      load_data    = buf_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;

      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (Redirect) begin
               pc_d = redirect_pc;
               if (imem.IMemGnt) state_d = DROP;
            end else if (imem.IMemGnt) begin
               fetch_pc_d = pc_q;
               pc_d       = pc_q + XLEN'(4);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (Redirect) begin
               pc_d    = redirect_pc;
               state_d = imem.IMemRvalid ? REQ : DROP;
            end else if (imem.IMemRvalid) begin
               if (acc) begin
                  load      = 1'b1;
                  load_data = imem.IMemRdata;
               end else begin
                  buf_d = imem.IMemRdata;
               end
               state_d = acc ? REQ : FULL;
            end
         end
         DROP: begin
            // A redirect here still retargets the PC even when the stale word returns
            if (Redirect)         pc_d    = redirect_pc;
            if (imem.IMemRvalid)  state_d = REQ;
         end
         FULL: begin
            if (Redirect) begin
               pc_d    = redirect_pc;
               state_d = REQ;
            end else if (acc) begin
               load    = 1'b1;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      if (Redirect) begin
         inst_d       = NOP;
         inst_valid_d = 1'b0;
      end else if (load) begin
         inst_d       = load_data;
         inst_pc_d    = fetch_pc_q;
         inst_valid_d = 1'b1;
      end else if (!(Stall && inst_valid_q)) begin
         inst_d       = NOP;
         inst_valid_d = 1'b0;
      end

      req_d = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC_A;
         fetch_pc_q   <= RESET_PC_A;
         buf_q        <= '0;
         inst_q       <= NOP;
         inst_pc_q    <= RESET_PC_A;
         inst_valid_q <= 1'b0;
         req_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_pc_q   <= fetch_pc_d;
         buf_q        <= buf_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         req_q        <= req_d;
      end
   end

   assign imem.IMemReq  = req_q;
   assign imem.IMemAddr = pc_q;
   assign Inst          = inst_q;
   assign InstPC        = inst_pc_q;
   assign InstValid     = inst_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall buffering, redirects, wrap and reset.
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n, rst_n_w;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] inst, inst_pc, inst_w, inst_pc_w;
   logic        inst_valid, inst_valid_w;
   int          checks;
   int          failures;

   instruction_fetch_if bus ();
   instruction_fetch_if bus_w ();

   instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)) u_dut (
      .clk(clk), .rst_n(rst_n), .imem(bus.master),
      .Redirect(redirect), .RedirectPC(redirect_pc), .Stall(stall),
      .Inst(inst), .InstPC(inst_pc), .InstValid(inst_valid)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP(32'h0000_0013)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n_w), .imem(bus_w.master),
      .Redirect(redirect), .RedirectPC(redirect_pc), .Stall(stall),
      .Inst(inst_w), .InstPC(inst_pc_w), .InstValid(inst_valid_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      if (bus.IMemReq !== 1'b0) begin failures++; $display("FAIL rst_req act=%b exp=0", bus.IMemReq); end
      checks++;
      if (bus.IMemAddr !== 32'h0) begin failures++; $display("FAIL rst_addr act=%h exp=00000000", bus.IMemAddr); end
      checks++;
      if (inst !== 32'h13) begin failures++; $display("FAIL rst_inst act=%h exp=00000013", inst); end
      checks++;
      if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_instpc act=%h exp=00000000", inst_pc); end
      checks++;
      if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid act=%b exp=0", inst_valid); end
      checks++;
      if (bus_w.IMemAddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_w_addr act=%h exp=fffffffc", bus_w.IMemAddr); end
      checks++;
      if (inst_pc_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_w_instpc act=%h exp=fffffffc", inst_pc_w); end
      checks++;
      rst_n = 1'b1;
      // IDLE cycle: no request yet
      if (bus.IMemReq !== 1'b0) begin failures++; $display("FAIL idle_req act=%b exp=0", bus.IMemReq); end
      checks++;
      tick();
   endtask

   task automatic test_streaming();
      logic [31:0] a;
      for (int k = 0; k < 4; k++) begin
         a = 32'(k * 4);
         if (bus.IMemReq !== 1'b1) begin failures++; $display("FAIL str_req%0d act=%b exp=1", k, bus.IMemReq); end
         checks++;
         if (bus.IMemAddr !== a) begin failures++; $display("FAIL str_addr%0d act=%h exp=%h", k, bus.IMemAddr, a); end
         checks++;
         bus.IMemGnt = 1'b1;
         tick();
         bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = mem_word(a);
         if (inst_valid !== 1'b0) begin failures++; $display("FAIL str_wait_valid%0d act=%b exp=0", k, inst_valid); end
         checks++;
         tick();
         bus.IMemRvalid = 1'b0;
         if (inst_valid !== 1'b1) begin failures++; $display("FAIL str_valid%0d act=%b exp=1", k, inst_valid); end
         checks++;
         if (inst !== mem_word(a)) begin failures++; $display("FAIL str_inst%0d act=%h exp=%h", k, inst, mem_word(a)); end
         checks++;
         if (inst_pc !== a) begin failures++; $display("FAIL str_pc%0d act=%h exp=%h", k, inst_pc, a); end
         checks++;
      end
   endtask

   task automatic test_stall_buffer();
      // Holding Inst from 0xC; fetch 0x10 while decode is stalled
      stall = 1'b1; bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = 32'h0050_0093;
      tick();
      bus.IMemRvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (bus.IMemReq !== 1'b0) begin failures++; $display("FAIL full_req%0d act=%b exp=0", c, bus.IMemReq); end
         checks++;
         if (inst !== mem_word(32'hC)) begin failures++; $display("FAIL full_inst%0d act=%h exp=%h", c, inst, mem_word(32'hC)); end
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin
            failures++; $display("FAIL full_hold%0d act=%b/%h exp=1/0000000c", c, inst_valid, inst_pc);
         end
         checks++;
         tick();
      end
      stall = 1'b0;
      tick();
      if (inst !== 32'h0050_0093) begin failures++; $display("FAIL unstall_inst act=%h exp=00500093", inst); end
      checks++;
      if (inst_pc !== 32'h10) begin failures++; $display("FAIL unstall_pc act=%h exp=00000010", inst_pc); end
      checks++;
      if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h14) begin
         failures++; $display("FAIL unstall_req act=%b/%h exp=1/00000014", bus.IMemReq, bus.IMemAddr);
      end
      checks++;
   endtask

   task automatic test_redirect_wait();
      bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      if (inst_valid !== 1'b0 || inst !== 32'h13) begin
         failures++; $display("FAIL rw_flush act=%b/%h exp=0/00000013", inst_valid, inst);
      end
      checks++;
      bus.IMemRvalid = 1'b1; bus.IMemRdata = 32'hDEAD_BEEF;
      tick();
      bus.IMemRvalid = 1'b0;
      if (inst_valid !== 1'b0 || inst !== 32'h13) begin
         failures++; $display("FAIL rw_stale act=%b/%h exp=0/00000013", inst_valid, inst);
      end
      checks++;
      if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h100) begin
         failures++; $display("FAIL rw_addr act=%b/%h exp=1/00000100", bus.IMemReq, bus.IMemAddr);
      end
      checks++;
      bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = mem_word(32'h100);
      tick();
      bus.IMemRvalid = 1'b0;
      if (inst !== mem_word(32'h100) || inst_pc !== 32'h100) begin
         failures++; $display("FAIL rw_refetch act=%h/%h exp=%h/00000100", inst, inst_pc, mem_word(32'h100));
      end
      checks++;
   endtask

   task automatic test_redirect_grant();
      bus.IMemGnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      bus.IMemGnt = 1'b0; redirect = 1'b0;
      if (inst_valid !== 1'b0 || bus.IMemReq !== 1'b0) begin
         failures++; $display("FAIL rg_drop act=%b/%b exp=0/0", inst_valid, bus.IMemReq);
      end
      checks++;
      bus.IMemRvalid = 1'b1; bus.IMemRdata = mem_word(32'h104);
      tick();
      bus.IMemRvalid = 1'b0;
      if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h200 || inst_valid !== 1'b0) begin
         failures++; $display("FAIL rg_resume act=%b/%h/%b exp=1/00000200/0", bus.IMemReq, bus.IMemAddr, inst_valid);
      end
      checks++;
      bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = mem_word(32'h200);
      tick();
      bus.IMemRvalid = 1'b0;
      if (inst !== mem_word(32'h200) || inst_pc !== 32'h200) begin
         failures++; $display("FAIL rg_refetch act=%h/%h exp=%h/00000200", inst, inst_pc, mem_word(32'h200));
      end
      checks++;
   endtask

   task automatic test_redirect_full();
      stall = 1'b1; bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = 32'hBAD0_0013;
      tick();
      bus.IMemRvalid = 1'b0;
      if (bus.IMemReq !== 1'b0 || inst !== mem_word(32'h200)) begin
         failures++; $display("FAIL rf_full act=%b/%h exp=0/%h", bus.IMemReq, inst, mem_word(32'h200));
      end
      checks++;
      redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0; stall = 1'b0;
      if (inst_valid !== 1'b0 || inst !== 32'h13 || inst_pc !== 32'h200) begin
         failures++; $display("FAIL rf_flush act=%b/%h/%h exp=0/00000013/00000200", inst_valid, inst, inst_pc);
      end
      checks++;
      if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h100) begin
         failures++; $display("FAIL rf_addr act=%b/%h exp=1/00000100", bus.IMemReq, bus.IMemAddr);
      end
      checks++;
      bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = mem_word(32'h100);
      tick();
      bus.IMemRvalid = 1'b0;
      if (inst !== mem_word(32'h100) || inst_pc !== 32'h100 || inst_valid !== 1'b1) begin
         failures++; $display("FAIL rf_refetch act=%h/%h/%b exp=%h/00000100/1", inst, inst_pc, inst_valid, mem_word(32'h100));
      end
      checks++;
   endtask

   task automatic test_reset_mid_wait();
      bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0;
      rst_n = 1'b0;
      #1;
      if (bus.IMemReq !== 1'b0 || bus.IMemAddr !== 32'h0) begin
         failures++; $display("FAIL mr_req act=%b/%h exp=0/00000000", bus.IMemReq, bus.IMemAddr);
      end
      checks++;
      if (inst !== 32'h13 || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin
         failures++; $display("FAIL mr_out act=%h/%h/%b exp=00000013/00000000/0", inst, inst_pc, inst_valid);
      end
      checks++;
      bus.IMemRvalid = 1'b1; bus.IMemRdata = 32'hDEAD_0013;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      bus.IMemRvalid = 1'b0;
      if (inst_valid !== 1'b0 || inst !== 32'h13 || bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0) begin
         failures++; $display("FAIL mr_late act=%b/%h/%b/%h exp=0/00000013/1/00000000", inst_valid, inst, bus.IMemReq, bus.IMemAddr);
      end
      checks++;
      bus.IMemGnt = 1'b1;
      tick();
      bus.IMemGnt = 1'b0; bus.IMemRvalid = 1'b1; bus.IMemRdata = mem_word(32'h0);
      tick();
      bus.IMemRvalid = 1'b0;
      if (inst !== mem_word(32'h0) || inst_pc !== 32'h0 || inst_valid !== 1'b1) begin
         failures++; $display("FAIL mr_fetch act=%h/%h/%b exp=%h/00000000/1", inst, inst_pc, inst_valid, mem_word(32'h0));
      end
      checks++;
   endtask

   task automatic test_wrap();
      rst_n_w = 1'b1;
      tick();
      if (bus_w.IMemReq !== 1'b1 || bus_w.IMemAddr !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wr_first act=%b/%h exp=1/fffffffc", bus_w.IMemReq, bus_w.IMemAddr);
      end
      checks++;
      bus_w.IMemGnt = 1'b1;
      tick();
      bus_w.IMemGnt = 1'b0; bus_w.IMemRvalid = 1'b1; bus_w.IMemRdata = mem_word(32'hFFFF_FFFC);
      tick();
      bus_w.IMemRvalid = 1'b0;
      if (bus_w.IMemReq !== 1'b1 || bus_w.IMemAddr !== 32'h0) begin
         failures++; $display("FAIL wr_second act=%b/%h exp=1/00000000", bus_w.IMemReq, bus_w.IMemAddr);
      end
      checks++;
      if (inst_w !== mem_word(32'hFFFF_FFFC) || inst_pc_w !== 32'hFFFF_FFFC || inst_valid_w !== 1'b1) begin
         failures++; $display("FAIL wr_inst act=%h/%h/%b exp=%h/fffffffc/1", inst_w, inst_pc_w, inst_valid_w, mem_word(32'hFFFF_FFFC));
      end
      checks++;
      bus_w.IMemGnt = 1'b1;
      tick();
      bus_w.IMemGnt = 1'b0; bus_w.IMemRvalid = 1'b1; bus_w.IMemRdata = mem_word(32'h0);
      tick();
      bus_w.IMemRvalid = 1'b0;
      if (inst_pc_w !== 32'h0 || bus_w.IMemAddr !== 32'h4) begin
         failures++; $display("FAIL wr_third act=%h/%h exp=00000000/00000004", inst_pc_w, bus_w.IMemAddr);
      end
      checks++;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b1; rst_n_w = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
      bus.IMemGnt = 1'b0; bus.IMemRdata = 32'h0; bus.IMemRvalid = 1'b0;
      bus_w.IMemGnt = 1'b0; bus_w.IMemRdata = 32'h0; bus_w.IMemRvalid = 1'b0;
      #2;
      rst_n = 1'b0; rst_n_w = 1'b0;
      tick();
      tick();
      test_reset();
      test_streaming();
      test_stall_buffer();
      test_redirect_wait();
      test_redirect_grant();
      test_redirect_full();
      test_reset_mid_wait();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
